// File: rtl/seq_mult_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package seq_mult_pkg;

  localparam int SEQ_MULT_WIDTH = 32;
  localparam int CBA_WIDTH      = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int cnt_w(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/seq_shift_add_mult_cba.sv
// Carry-bypass adder: 4-bit ripple blocks whose carry skips the block when
// every bit of the block propagates.
module seq_shift_add_mult_cba #(
  parameter int WIDTH = 32,
  parameter int BLK   = 4
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_of
);

  localparam int NBLK = WIDTH / BLK;

  if ((WIDTH % BLK) != 0) begin : g_blk_chk
    $error("seq_shift_add_mult_cba: WIDTH must be a multiple of BLK");
  end

  // Ripple inside each block; the block carry-out bypasses on full propagate.
  always_comb begin
    logic v_c;
    logic v_blk_c;
    logic v_all_p;
    logic v_p;
    o_sum   = {WIDTH{1'b0}};
    v_c     = i_cin;
    v_blk_c = 1'b0;
    v_all_p = 1'b0;
    v_p     = 1'b0;
    for (int g = 0; g < NBLK; g++) begin
      v_blk_c = v_c;
      v_all_p = 1'b1;
      for (int k = 0; k < BLK; k++) begin
        v_p              = i_a[g*BLK+k] ^ i_b[g*BLK+k];
        o_sum[g*BLK+k]   = v_p ^ v_blk_c;
        v_blk_c          = (i_a[g*BLK+k] & i_b[g*BLK+k]) | (v_p & v_blk_c);
        v_all_p          = v_all_p & v_p;
      end
      v_c = v_all_p ? v_c : v_blk_c;
    end
    o_cout = v_c;
  end

  assign o_of = (i_a[WIDTH-1] ~^ i_b[WIDTH-1]) & (o_sum[WIDTH-1] ^ i_a[WIDTH-1]);

endmodule

// File: rtl/seq_shift_add_mult.sv
// Iterative radix-2 shift-add multiplier built around the carry-bypass adder.
// Optional two's-complement operands when SEQ_MULT_SIGNED_EN is defined.
module seq_shift_add_mult
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = SEQ_MULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product_o,
  output logic               busy_o
);

  localparam int CNT_W = cnt_w(WIDTH);

  if (WIDTH != CBA_WIDTH) begin : g_width_chk
    $error("seq_shift_add_mult: WIDTH must equal the CBA width");
  end

  state_e             r_state;
  state_e             w_next_state;
  logic [WIDTH-1:0]   r_m;
  logic [WIDTH-1:0]   r_p_hi;
  logic [WIDTH-1:0]   r_p_lo;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               r_busy;
  logic               w_accept;
  logic               w_last;
  logic [WIDTH-1:0]   w_add_b;
  logic [WIDTH-1:0]   w_sum;
  logic               w_cout;
  logic               w_of_unused;
  logic [WIDTH-1:0]   w_a_load;
  logic [WIDTH-1:0]   w_b_load;

  assign w_accept = in_valid && r_in_ready;
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_add_b  = r_p_lo[0] ? r_m : {WIDTH{1'b0}};

`ifdef SEQ_MULT_SIGNED_EN
  logic r_neg;
  // -2^(W-1) negates to itself, which is its correct unsigned magnitude.
  assign w_a_load  = a_i[WIDTH-1] ? (~a_i + {{(WIDTH-1){1'b0}}, 1'b1}) : a_i;
  assign w_b_load  = b_i[WIDTH-1] ? (~b_i + {{(WIDTH-1){1'b0}}, 1'b1}) : b_i;
  assign product_o = r_neg ? (~{r_p_hi, r_p_lo} + {{(2*WIDTH-1){1'b0}}, 1'b1})
                           : {r_p_hi, r_p_lo};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_neg <= 1'b0;
    end else if (r_state == IDLE && w_accept) begin
      r_neg <= a_i[WIDTH-1] ^ b_i[WIDTH-1];
    end else begin
      r_neg <= r_neg;
    end
  end
`else
  assign w_a_load  = a_i;
  assign w_b_load  = b_i;
  assign product_o = {r_p_hi, r_p_lo};
`endif

  seq_shift_add_mult_cba #(.WIDTH(WIDTH)) u_cba (
    .i_a    (r_p_hi),
    .i_b    (w_add_b),
    .i_cin  (1'b0),
    .o_sum  (w_sum),
    .o_cout (w_cout),
    .o_of   (w_of_unused)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    w_next_state = w_accept  ? RUN  : IDLE;
      RUN:     w_next_state = w_last    ? DONE : RUN;
      DONE:    w_next_state = out_ready ? IDLE : DONE;
      default: w_next_state = IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so no input reaches them combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_m         <= {WIDTH{1'b0}};
      r_p_hi      <= {WIDTH{1'b0}};
      r_p_lo      <= {WIDTH{1'b0}};
      r_cnt       <= {CNT_W{1'b0}};
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_in_ready  <= (w_next_state == IDLE);
      r_out_valid <= (w_next_state == DONE);
      r_busy      <= (w_next_state != IDLE);
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_m    <= w_a_load;
            r_p_lo <= w_b_load;
            r_p_hi <= {WIDTH{1'b0}};
            r_cnt  <= {CNT_W{1'b0}};
          end
        end
        RUN: begin
          {r_p_hi, r_p_lo} <= {w_cout, w_sum, r_p_lo[WIDTH-1:1]};
          r_cnt            <= r_cnt + CNT_W'(1);
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy_o    = r_busy;

endmodule
